// File: rtl/apb_requester.sv
// apb_requester
//   APB (AMBA 3) requester. Accepts single-beat commands on the cmd_* port,
//   runs them as APB SETUP/ACCESS transfers and reports completion on the
//   rsp_* port as a one-cycle pulse.
//
// Parameters
//   TIMEOUT_CYCLES : maximum ACCESS cycles to wait for pready (0 = no timeout)
//
// Ports
//   pclk, preset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (ready only while idle)
//   cmd_write/addr/wdata    : command direction, address, write data
//   rsp_valid               : one-cycle completion pulse
//   rsp_rdata/err/timeout   : read data, error flag, timeout flag (held)
//   psel/penable/pwrite/paddr/pwdata : APB request outputs (registered)
//   prdata/pready/pslverr   : APB response inputs (sampled in ACCESS only)
module apb_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // Keep the counter at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state;
  logic [CW-1:0]   wcnt;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      wcnt        <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          penable <= 1'b0;
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end else begin
            psel <= 1'b0;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            // Read data is only meaningful for an error-free read.
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && wcnt == WAIT_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_requester #(.TIMEOUT_CYCLES(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // Behavioural APB RAM responder: 32 words, programmable wait states,
  // pready can be tied low, out-of-range addresses return pslverr.
  logic [31:0] mem [0:31];
  int unsigned wait_states = 0;
  logic        tie_low = 1'b0;
  int unsigned acc_cnt = 0;

  assign pready  = psel && penable && !tie_low && (acc_cnt >= wait_states);
  assign pslverr = (paddr >= 32'd32);
  assign prdata  = (paddr < 32'd32) ? mem[paddr[4:0]] : 32'hBAD0BAD0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && paddr < 32'd32)
      mem[paddr[4:0]] <= pwdata;
  end

  // Issue one command from a negedge with the requester idle and measure the
  // transfer: lat = negedges from acceptance until rsp_valid (-1 if none
  // within 40), acc = ACCESS cycles, stalls = ACCESS cycles without pready,
  // stable = request fields unchanged while psel, ph1/ph2 = {psel,penable}
  // in the first and second cycle after acceptance.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int acc, output int stalls,
                      output bit stable, output logic [1:0] ph1, output logic [1:0] ph2);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    lat = 1; acc = 0; stalls = 0; stable = 1'b1; ph1 = 2'bxx; ph2 = 2'bxx;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (lat == 1) ph1 = {psel, penable};
      if (lat == 2) ph2 = {psel, penable};
      if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== d))) stable = 1'b0;
      if (penable) begin
        acc++;
        if (!pready) stalls++;
      end
      @(negedge pclk);
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(posedge pclk);
    #2 preset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000001", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready});
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h expected all 0", paddr, pwdata, rsp_rdata);
    end
    @(negedge pclk);
    preset = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge pclk);
      if (psel !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_hold: psel/cmd_ready left 0/1 during idle, got %b/%b", psel, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    int lat, acc, stalls;
    bit stable;
    logic [1:0] ph1, ph2;
    send(1'b1, 32'd5, 32'hDEADBEEF, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++;
    if (ph1 !== 2'b10 || ph2 !== 2'b11) begin
      errors++; $display("FAIL wr_phases: got setup=%b access=%b expected 10/11", ph1, ph2);
    end
    checks++;
    if ({rsp_err, rsp_timeout, psel, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL wr_rsp: err/to/psel/ready got %b expected 0001", {rsp_err, rsp_timeout, psel, cmd_ready});
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL wr_stable: request fields changed, got 0 expected 1"); end
    @(negedge pclk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse: rsp_valid got %b expected 0", rsp_valid); end

    send(1'b0, 32'd5, 32'd0, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata=%h err=%b to=%b expected deadbeef/0/0", rsp_rdata, rsp_err, rsp_timeout);
    end
    checks++;
    if (pwrite !== 1'b0 || paddr !== 32'd5) begin
      errors++; $display("FAIL rd_hold: pwrite=%b paddr=%h expected 0/5", pwrite, paddr);
    end
  endtask

  task automatic test_slverr();
    int lat, acc, stalls;
    bit stable;
    logic [1:0] ph1, ph2;
    send(1'b0, 32'd40, 32'd0, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL err_latency: got %0d expected 3", lat); end
    checks++;
    if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL err_rsp: err=%b to=%b rdata=%h expected 1/0/0", rsp_err, rsp_timeout, rsp_rdata);
    end
  endtask

  task automatic test_wait_states();
    int lat, acc, stalls, pulses;
    bit stable;
    logic [1:0] ph1, ph2;
    wait_states = 4;
    send(1'b1, 32'd7, 32'h12345678, lat, acc, stalls, stable, ph1, ph2);
    pulses = (rsp_valid === 1'b1) ? 1 : 0;
    wait_states = 0;
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL ws_latency: got %0d expected 7", lat); end
    checks++;
    if (acc !== 5 || stalls !== 4) begin
      errors++; $display("FAIL ws_access: access=%0d stalls=%0d expected 5/4", acc, stalls);
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL ws_stable: request fields changed, got 0 expected 1"); end
    repeat (5) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ws_pulses: got %0d expected 1", pulses); end
    checks++;
    if (mem[7] !== 32'h12345678) begin errors++; $display("FAIL ws_mem: got %h expected 12345678", mem[7]); end
  endtask

  task automatic test_timeout();
    int lat, acc, stalls;
    bit stable;
    logic [1:0] ph1, ph2;
    tie_low = 1'b1;
    send(1'b0, 32'd3, 32'd0, lat, acc, stalls, stable, ph1, ph2);
    tie_low = 1'b0;
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL to_latency: got %0d expected 18", lat); end
    checks++;
    if (acc !== 16) begin errors++; $display("FAIL to_access: got %0d expected 16", acc); end
    checks++;
    if ({rsp_err, rsp_timeout, psel} !== 3'b110 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL to_rsp: err/to/psel=%b rdata=%h expected 110/0", {rsp_err, rsp_timeout, psel}, rsp_rdata);
    end
    send(1'b1, 32'd9, 32'hCAFEF00D, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (lat !== 3 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL to_next: lat=%0d err=%b to=%b expected 3/0/0", lat, rsp_err, rsp_timeout);
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    tie_low = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'd2;
    cmd_valid = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if (penable !== 1'b1) begin errors++; $display("FAIL mid_in_access: penable got %b expected 1", penable); end
    #2 preset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL mid_reset: psel/penable/rsp_valid/ready got %b expected 0001", {psel, penable, rsp_valid, cmd_ready});
    end
    @(negedge pclk);
    preset = 1'b0;
    tie_low = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int  acc_at [8];
    int  n_acc, nrsp, lat, acc, stalls;
    bit  accepted, psel_ok, stable;
    logic [1:0] ph1, ph2;
    n_acc = 0; nrsp = 0; psel_ok = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'd16;
    cmd_wdata = 32'hA5000000;
    cmd_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid === 1'b1) nrsp++;
      accepted = 1'b0;
      if (cmd_valid && cmd_ready === 1'b1 && n_acc < 8) begin
        acc_at[n_acc] = c;
        n_acc++;
        accepted = 1'b1;
        if (psel !== 1'b0) psel_ok = 1'b0;
      end
      @(negedge pclk);
      if (accepted) begin
        if (n_acc == 8) cmd_valid = 1'b0;
        else begin
          cmd_addr  = 32'(16 + n_acc);
          cmd_wdata = 32'hA5000000 + 32'(n_acc);
        end
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (n_acc !== 8 || nrsp !== 8) begin
      errors++; $display("FAIL b2b_count: accepted=%0d responses=%0d expected 8/8", n_acc, nrsp);
    end
    for (int i = 1; i < n_acc; i++) begin
      checks++;
      if (acc_at[i] - acc_at[i-1] !== 3) begin
        errors++; $display("FAIL b2b_gap%0d: got %0d expected 3", i, acc_at[i] - acc_at[i-1]);
      end
    end
    checks++;
    if (!psel_ok) begin errors++; $display("FAIL b2b_psel_gap: psel high at acceptance, got 1 expected 0"); end
    send(1'b0, 32'd23, 32'd0, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (rsp_rdata !== 32'hA5000007) begin errors++; $display("FAIL b2b_last: got %h expected a5000007", rsp_rdata); end
    send(1'b0, 32'd16, 32'd0, lat, acc, stalls, stable, ph1, ph2);
    checks++;
    if (rsp_rdata !== 32'hA5000000) begin errors++; $display("FAIL b2b_first: got %h expected a5000000", rsp_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_slverr();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
